// File: rtl/memory_bus_arbiter_if.sv
// memory_bus_arbiter_if: fetch/data requester handshakes and the external memory port.
interface memory_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              FetchReq;
  logic [ADDR_W-1:0] FetchAddr;
  logic              FetchDone;
  logic [DATA_W-1:0] FetchData;
  logic              DataReq;
  logic [1:0]        DataOp;
  logic [ADDR_W-1:0] DataAddr;
  logic [DATA_W-1:0] DataWrData;
  logic              DataDone;
  logic [DATA_W-1:0] DataRdData;
  logic [1:0]        MemOp;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWrData;
  logic              MemReady;
  logic [DATA_W-1:0] MemRdData;
  logic              BusError;

  modport master (
    input  FetchReq, FetchAddr, DataReq, DataOp, DataAddr, DataWrData, MemReady, MemRdData,
    output FetchDone, FetchData, DataDone, DataRdData, MemOp, MemAddr, MemWrData, BusError
  );

  modport slave (
    output FetchReq, FetchAddr, DataReq, DataOp, DataAddr, DataWrData, MemReady, MemRdData,
    input  FetchDone, FetchData, DataDone, DataRdData, MemOp, MemAddr, MemWrData, BusError
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: shares one external memory port between fetch and data requesters,
// alternating priority on ties, with a watchdog that aborts hung exchanges.
module memory_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  memory_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} stateT;
  stateT state, nextState;
  logic owner, lastOwner;
  logic [15:0] wdCount;
  logic [1:0] memOp;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWrData, fetchData, dataRdData;
  logic fetchDone, dataDone, busError;
  logic fetchOk, dataOk, pickData, grant, illegal, start, ready, expired, accExpire, relExpire, finish;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;

  always_comb
    nextState = state == IDLE ? (start ? ACCESS : IDLE)
              : state == ACCESS ? (ready ? RELEASE : accExpire ? IDLE : ACCESS)
              : (!bus.MemReady || relExpire) ? IDLE : RELEASE;

  // A requester whose Done is showing this cycle is treated as already served.
  always_comb begin
    fetchOk = bus.FetchReq && !fetchDone;
    dataOk = bus.DataReq && !dataDone;
    pickData = dataOk && (!fetchOk || !lastOwner);
    grant = state == IDLE && (fetchOk || dataOk);
    illegal = grant && pickData && bus.DataOp != 2'b01 && bus.DataOp != 2'b10;
    start = grant && !illegal;
    ready = state == ACCESS && bus.MemReady;
    expired = wdCount == 16'(TIMEOUT - 1);
    accExpire = state == ACCESS && !bus.MemReady && expired;
    relExpire = state == RELEASE && bus.MemReady && expired;
    finish = ready || accExpire;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner <= 1'b0;
      lastOwner <= 1'b0;
      wdCount <= '0;
      memOp <= 2'b00;
      memAddr <= '0;
      memWrData <= '0;
      fetchData <= '0;
      dataRdData <= '0;
      fetchDone <= 1'b0;
      dataDone <= 1'b0;
      busError <= 1'b0;
    end else begin
      wdCount <= (state == IDLE || ready) ? '0 : wdCount + 16'd1;
      fetchDone <= finish && !owner;
      dataDone <= (finish && owner) || illegal;
      if (start) begin
        owner <= pickData;
        memOp <= pickData ? bus.DataOp : 2'b01;
        memAddr <= pickData ? bus.DataAddr : bus.FetchAddr;
        if (pickData && bus.DataOp == 2'b10) memWrData <= bus.DataWrData;
      end else if (finish) memOp <= 2'b00;
      if (finish) lastOwner <= owner;
      if (ready && !owner) fetchData <= bus.MemRdData;
      if (ready && owner && memOp == 2'b01) dataRdData <= bus.MemRdData;
      if (illegal || accExpire || relExpire) busError <= 1'b1;
    end

  assign bus.MemOp = memOp;
  assign bus.MemAddr = memAddr;
  assign bus.MemWrData = memWrData;
  assign bus.FetchData = fetchData;
  assign bus.DataRdData = dataRdData;
  assign bus.FetchDone = fetchDone;
  assign bus.DataDone = dataDone;
  assign bus.BusError = busError;
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_memory_bus_arbiter;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  memory_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  int nCompared = 0;
  int nMismatched = 0;

  int respDelay = 4;
  int holdExtra = 0;
  bit hang = 1'b0;
  bit fixedOn = 1'b1;
  bit randMode = 1'b0;
  logic [31:0] fixedRd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory side: answers each bus cycle after a delay, optionally holds ready, or never answers.
  initial begin
    int ms, cnt, d, h;
    bit hg;
    ms = 0; cnt = 0;
    bus.MemReady = 1'b0;
    bus.MemRdData = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.MemReady = 1'b0;
        ms = 0;
      end else if (ms == 0) begin
        if (bus.MemOp != 2'b00) begin
          d = randMode ? int'($urandom_range(1, 6)) : respDelay;
          hg = randMode ? ($urandom_range(0, 11) == 0) : hang;
          cnt = d;
          ms = hg ? 4 : 1;
        end
      end else if (ms == 1) begin
        if (bus.MemOp == 2'b00) ms = 0;
        else begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            bus.MemReady = 1'b1;
            bus.MemRdData = fixedOn ? fixedRd : $urandom;
            ms = 2;
          end
        end
      end else if (ms == 2) begin
        if (bus.MemOp == 2'b00) begin
          h = randMode ? ($urandom_range(0, 3) == 0 ? int'($urandom_range(7, 10)) : int'($urandom_range(0, 2))) : holdExtra;
          if (h == 0) begin
            bus.MemReady = 1'b0;
            ms = 0;
          end else begin
            cnt = h;
            ms = 3;
          end
        end
      end else if (ms == 3) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          bus.MemReady = 1'b0;
          ms = 0;
        end
      end else if (bus.MemOp == 2'b00) ms = 0;
    end
  end

  // Behavioural model: phase 0 = bus free, 1 = waiting for ready, 2 = waiting for ready to drop.
  int phase = 0;
  int ticks = 0;
  bit whoData = 1'b0, lastData = 1'b0;
  bit fWants, dWants, dWins, finishNow;
  logic [1:0] eOp = '0;
  logic [31:0] eAddr = '0, eWr = '0, eFData = '0, eDData = '0;
  logic eFD = 1'b0, eDD = 1'b0, eErr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; ticks = 0; lastData = 1'b0; whoData = 1'b0;
      eOp = '0; eAddr = '0; eWr = '0; eFData = '0; eDData = '0;
      eFD = 1'b0; eDD = 1'b0; eErr = 1'b0;
    end else begin
      fWants = bus.FetchReq && !eFD;
      dWants = bus.DataReq && !eDD;
      eFD = 1'b0;
      eDD = 1'b0;
      finishNow = 1'b0;
      if (phase == 0) begin
        if (fWants || dWants) begin
          dWins = dWants && (!fWants || !lastData);
          if (dWins && !(bus.DataOp inside {2'b01, 2'b10})) begin
            eDD = 1'b1;
            eErr = 1'b1;
          end else begin
            whoData = dWins;
            phase = 1;
            ticks = 0;
            eAddr = dWins ? bus.DataAddr : bus.FetchAddr;
            eOp = dWins ? bus.DataOp : 2'b01;
            if (dWins && bus.DataOp == 2'b10) eWr = bus.DataWrData;
          end
        end
      end else if (phase == 1) begin
        ticks++;
        if (bus.MemReady) begin
          if (!whoData) eFData = bus.MemRdData;
          else if (eOp == 2'b01) eDData = bus.MemRdData;
          finishNow = 1'b1;
          phase = 2;
          ticks = 0;
        end else if (ticks == TMO) begin
          finishNow = 1'b1;
          eErr = 1'b1;
          phase = 0;
        end
      end else begin
        ticks++;
        if (!bus.MemReady) phase = 0;
        else if (ticks == TMO) begin
          eErr = 1'b1;
          phase = 0;
        end
      end
      if (finishNow) begin
        eOp = 2'b00;
        lastData = whoData;
        eFD = !whoData;
        eDD = whoData;
      end
    end
  end

  always @(negedge clk) begin
    chk("MemOp", bus.MemOp, eOp);
    chk("MemAddr", bus.MemAddr, eAddr);
    chk("MemWrData", bus.MemWrData, eWr);
    chk("FetchDone", bus.FetchDone, eFD);
    chk("DataDone", bus.DataDone, eDD);
    chk("FetchData", bus.FetchData, eFData);
    chk("DataRdData", bus.DataRdData, eDData);
    chk("BusError", bus.BusError, eErr);
  end

  task automatic waitDone(input bit isData, input string name);
    int k;
    k = 0;
    while (!(isData ? bus.DataDone : bus.FetchDone) && k < 100) begin
      tick(1);
      k++;
    end
    chk({name, " done seen"}, k < 100, 1);
    tick(1);
    chk({name, " single pulse"}, isData ? bus.DataDone : bus.FetchDone, 0);
  endtask

  initial begin
    #400000;
    nMismatched++;
    $display("FAIL global time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] order [4];
    logic [1:0] prevOp;
    int g, k, n;
    bus.FetchReq = 0; bus.FetchAddr = 0;
    bus.DataReq = 0; bus.DataOp = 0; bus.DataAddr = 0; bus.DataWrData = 0;
    tick(2);
    chk("rst MemOp", bus.MemOp, 0);
    chk("rst BusError", bus.BusError, 0);
    chk("rst FetchData", bus.FetchData, 0);
    rst_n = 1'b1;
    tick(1);

    // fetch only
    fixedRd = 339;
    bus.FetchAddr = 540;
    bus.FetchReq = 1;
    tick(1);
    chk("t1 MemOp", bus.MemOp, 1);
    chk("t1 MemAddr", bus.MemAddr, 540);
    waitDone(0, "t1");
    bus.FetchReq = 0;
    chk("t1 FetchData", bus.FetchData, 339);
    chk("t1 MemOp idle", bus.MemOp, 0);

    // data write
    tick(2);
    bus.DataOp = 2'b10; bus.DataAddr = 4467; bus.DataWrData = 555; bus.DataReq = 1;
    tick(1);
    chk("t2 MemOp", bus.MemOp, 2);
    chk("t2 MemAddr", bus.MemAddr, 4467);
    chk("t2 MemWrData", bus.MemWrData, 555);
    waitDone(1, "t2");
    bus.DataReq = 0;
    chk("t2 DataRdData", bus.DataRdData, 0);

    // simultaneous requests alternate, data first after reset
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    bus.FetchAddr = 32'h100; bus.DataAddr = 32'h200; bus.DataOp = 2'b01;
    bus.FetchReq = 1; bus.DataReq = 1;
    g = 0; k = 0; prevOp = bus.MemOp;
    while (g < 4 && k < 200) begin
      tick(1);
      k++;
      if (prevOp == 2'b00 && bus.MemOp != 2'b00) begin
        order[g] = bus.MemAddr;
        g++;
      end
      prevOp = bus.MemOp;
    end
    bus.FetchReq = 0; bus.DataReq = 0;
    chk("t3 grant count", g, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3 grant%0d", i), order[i], (i % 2 == 0) ? 32'h200 : 32'h100);
    tick(15);

    // memory keeps ready high three extra cycles
    holdExtra = 3;
    fixedRd = 32'h1234;
    bus.FetchAddr = 32'h300;
    bus.FetchReq = 1;
    waitDone(0, "t4 fetch");
    bus.FetchReq = 0;
    holdExtra = 0;
    fixedRd = 32'h77;
    bus.DataOp = 2'b01; bus.DataAddr = 32'h400; bus.DataReq = 1;
    k = 0;
    while (bus.MemOp == 2'b00 && k < 20) begin
      tick(1);
      k++;
    end
    chk("t4 grant delay", k, 4);
    waitDone(1, "t4 read");
    bus.DataReq = 0;
    chk("t4 DataRdData", bus.DataRdData, 32'h77);
    chk("t4 FetchData", bus.FetchData, 32'h1234);
    tick(6);

    // watchdog on a hung read
    hang = 1;
    bus.DataOp = 2'b01; bus.DataAddr = 32'h500; bus.DataReq = 1;
    k = 0; n = 0;
    while (!bus.DataDone && k < 50) begin
      tick(1);
      k++;
      if (bus.MemOp != 2'b00) n++;
    end
    chk("t5 DataDone", bus.DataDone, 1);
    chk("t5 MemOp cycles", n, 8);
    chk("t5 BusError", bus.BusError, 1);
    chk("t5 DataRdData kept", bus.DataRdData, 32'h77);
    tick(1);
    bus.DataReq = 0;
    chk("t5 single pulse", bus.DataDone, 0);
    hang = 0;
    fixedRd = 32'h999;
    bus.FetchAddr = 32'h600;
    bus.FetchReq = 1;
    waitDone(0, "t5 fetch");
    bus.FetchReq = 0;
    chk("t5 FetchData", bus.FetchData, 32'h999);

    // reset during ACCESS, then illegal op
    hang = 1;
    tick(2);
    bus.FetchAddr = 32'h700;
    bus.FetchReq = 1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("t6 MemOp", bus.MemOp, 0);
    chk("t6 MemAddr", bus.MemAddr, 0);
    chk("t6 BusError", bus.BusError, 0);
    chk("t6 FetchData", bus.FetchData, 0);
    chk("t6 DataRdData", bus.DataRdData, 0);
    bus.FetchReq = 0;
    hang = 0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("t6 no FetchDone", bus.FetchDone, 0);
    bus.DataOp = 2'b11; bus.DataReq = 1;
    tick(1);
    chk("t6 illegal DataDone", bus.DataDone, 1);
    chk("t6 illegal BusError", bus.BusError, 1);
    chk("t6 illegal MemOp", bus.MemOp, 0);
    tick(1);
    bus.DataReq = 0;
    chk("t6 illegal pulse", bus.DataDone, 0);
    chk("t6 MemOp still idle", bus.MemOp, 0);
    tick(3);

    // randomized traffic
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    fixedOn = 0;
    randMode = 1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          tick($urandom_range(0, 4));
          bus.FetchAddr = $urandom;
          bus.FetchReq = 1;
          if ($urandom_range(0, 9) == 0) begin
            tick(1);
            bus.FetchReq = 0;
          end else begin
            waitDone(0, "rnd fetch");
            bus.FetchReq = 0;
          end
        end
      end
      begin
        int r;
        for (int j = 0; j < 60; j++) begin
          tick($urandom_range(0, 4));
          r = $urandom_range(0, 11);
          bus.DataOp = r == 0 ? 2'b11 : r == 1 ? 2'b00 : r < 7 ? 2'b01 : 2'b10;
          bus.DataAddr = $urandom;
          bus.DataWrData = $urandom;
          bus.DataReq = 1;
          if ($urandom_range(0, 9) == 0) begin
            tick(1);
            bus.DataReq = 0;
          end else begin
            waitDone(1, "rnd data");
            bus.DataReq = 0;
          end
        end
      end
    join
    tick(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
